// File: rtl/cnn_stream_pkg.sv
// rtl/cnn_stream_pkg.sv - shared constants and window packing helper for the CNN stream datapath
package cnn_stream_pkg;

  localparam int DEF_DATA_W = 8;  // default pixel width
  localparam int K          = 3;  // window edge length

  // Bit offset of window element (r,c) inside a packed K*K window.
  function automatic int win_idx(input int r, input int c, input int dw = DEF_DATA_W);
    return (r * K + c) * dw;
  endfunction

endpackage

// File: rtl/line_buffer_row.sv
// rtl/line_buffer_row.sv - one image-row circular buffer, combinational read-before-write
// Ports: clk; we write enable; addr column; wdata new pixel; rdata old contents at addr.
module line_buffer_row #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 11,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Read is asynchronous, so rdata shows the value from the previous row
  // even in the cycle that overwrites it.
  assign rdata = r_mem[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/window_3x3_generator.sv
// rtl/window_3x3_generator.sv - raster pixel stream to 3x3 sliding windows with centre coordinates
// Ports: clk, rst (sync, active-high); data_in/data_valid pixel stream;
// window_out packed 3x3 window, window_valid, centre_row/centre_col, frame_done pulse.
module window_3x3_generator
  import cnn_stream_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int IMG_W  = 11,
  parameter int IMG_H  = 11,
  parameter int PTR_W  = $clog2(IMG_W),
  parameter int ROW_W  = $clog2(IMG_H)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     data_in,
  input  logic                  data_valid,
  output logic [9*DATA_W-1:0]   window_out,
  output logic                  window_valid,
  output logic [ROW_W-1:0]      centre_row,
  output logic [PTR_W-1:0]      centre_col,
  output logic                  frame_done
);

  localparam logic [0:0] ST_FILL   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  logic [0:0]        r_state;
  logic [PTR_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;
  logic [DATA_W-1:0] r_win [K][K];

  logic [DATA_W-1:0] w_lb0_rd;
  logic [DATA_W-1:0] w_lb1_rd;
  logic              w_last_col;
  logic              w_last_row;
  logic              w_win_ok;

  // lb0 holds row-1; its displaced pixel cascades into lb1 (row-2).
  line_buffer_row #(.DATA_W(DATA_W), .DEPTH(IMG_W), .ADDR_W(PTR_W)) u_lb0 (
    .clk   (clk),
    .we    (data_valid),
    .addr  (r_col),
    .wdata (data_in),
    .rdata (w_lb0_rd)
  );

  line_buffer_row #(.DATA_W(DATA_W), .DEPTH(IMG_W), .ADDR_W(PTR_W)) u_lb1 (
    .clk   (clk),
    .we    (data_valid),
    .addr  (r_col),
    .wdata (w_lb0_rd),
    .rdata (w_lb1_rd)
  );

  assign w_last_col = (r_col == PTR_W'(IMG_W - 1));
  assign w_last_row = (r_row == ROW_W'(IMG_H - 1));
  // Left columns are stale until col>=2 and buffers are unwritten until row>=2.
  assign w_win_ok   = (r_state == ST_STREAM) && (r_row >= ROW_W'(2)) && (r_col >= PTR_W'(2));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_FILL;
      r_col        <= '0;
      r_row        <= '0;
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
      centre_row   <= '0;
      centre_col   <= '0;
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          r_win[r][c] <= '0;
        end
      end
    end else begin
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
      if (data_valid) begin
        for (int r = 0; r < K; r++) begin
          r_win[r][0] <= r_win[r][1];
          r_win[r][1] <= r_win[r][2];
        end
        r_win[0][2] <= w_lb1_rd;
        r_win[1][2] <= w_lb0_rd;
        r_win[2][2] <= data_in;

        if (w_last_col) begin
          r_col <= '0;
          if ((r_state == ST_STREAM) && w_last_row) begin
            r_row   <= '0;
            r_state <= ST_FILL;
          end else begin
            r_row <= r_row + ROW_W'(1);
            if (r_row == ROW_W'(1)) begin
              r_state <= ST_STREAM;
            end
          end
        end else begin
          r_col <= r_col + PTR_W'(1);
        end

        if (w_win_ok) begin
          window_valid <= 1'b1;
          centre_row   <= r_row - ROW_W'(1);
          centre_col   <= r_col - PTR_W'(1);
        end
        frame_done <= (r_state == ST_STREAM) && w_last_row && w_last_col;
      end
    end
  end

  always_comb begin
    window_out = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        window_out[win_idx(r, c, DATA_W) +: DATA_W] = r_win[r][c];
      end
    end
  end

endmodule

// File: tb/tb_window_3x3_generator.sv
// tb/tb_window_3x3_generator.sv - directed and reference-model bench for window_3x3_generator
module tb_window_3x3_generator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 4x4 instance
  logic        s_rst;
  logic [7:0]  s_din;
  logic        s_dv;
  logic [71:0] s_win;
  logic        s_wv;
  logic [1:0]  s_cr;
  logic [1:0]  s_cc;
  logic        s_fd;

  // 11x11 instance
  logic        b_rst;
  logic [7:0]  b_din;
  logic        b_dv;
  logic [71:0] b_win;
  logic        b_wv;
  logic [3:0]  b_cr;
  logic [3:0]  b_cc;
  logic        b_fd;

  window_3x3_generator #(.DATA_W(8), .IMG_W(4), .IMG_H(4)) u_small (
    .clk          (clk),
    .rst          (s_rst),
    .data_in      (s_din),
    .data_valid   (s_dv),
    .window_out   (s_win),
    .window_valid (s_wv),
    .centre_row   (s_cr),
    .centre_col   (s_cc),
    .frame_done   (s_fd)
  );

  window_3x3_generator #(.DATA_W(8), .IMG_W(11), .IMG_H(11)) u_big (
    .clk          (clk),
    .rst          (b_rst),
    .data_in      (b_din),
    .data_valid   (b_dv),
    .window_out   (b_win),
    .window_valid (b_wv),
    .centre_row   (b_cr),
    .centre_col   (b_cc),
    .frame_done   (b_fd)
  );

  int n_checks = 0;
  int n_errors = 0;
  int win_cnt;
  int fd_cnt;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Hand-computed windows of the 4x4 frame pixel(r,c)=r*4+c+1, centres (1,1),(1,2),(2,1),(2,2).
  function automatic logic [71:0] exp_win4(input int idx, input int off);
    int tbl [4][9];
    logic [71:0] w;
    tbl[0] = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
    tbl[1] = '{2, 3, 4, 6, 7, 8, 10, 11, 12};
    tbl[2] = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
    tbl[3] = '{6, 7, 8, 10, 11, 12, 14, 15, 16};
    w = '0;
    for (int i = 0; i < 9; i++) begin
      w[i*8 +: 8] = 8'(tbl[idx][i] + off);
    end
    return w;
  endfunction

  task automatic send4(input int off, input bit gaps, input int npix);
    int r, c, idx;
    bit exp_v;
    for (int p = 0; p < npix; p++) begin
      r = p / 4;
      c = p % 4;
      s_din = 8'(off + p + 1);
      s_dv  = 1'b1;
      @(posedge clk); #1;
      exp_v = (r >= 2) && (c >= 2);
      idx   = (r - 2) * 2 + (c - 2);
      check("s_wv", s_wv, exp_v);
      check("s_fd", s_fd, (p == 15));
      if (s_wv) win_cnt++;
      if (s_fd) fd_cnt++;
      if (exp_v) begin
        check("s_win", s_win, exp_win4(idx, off));
        check("s_crow", s_cr, r - 1);
        check("s_ccol", s_cc, c - 1);
      end
      if (gaps) begin
        s_dv = 1'b0;
        @(posedge clk); #1;
        check("gap_wv", s_wv, 0);
        check("gap_fd", s_fd, 0);
        if (s_wv) win_cnt++;
        if (s_fd) fd_cnt++;
        if (exp_v) begin
          check("gap_win_hold", s_win, exp_win4(idx, off));
          check("gap_crow_hold", s_cr, r - 1);
          check("gap_ccol_hold", s_cc, c - 1);
        end
      end
    end
    s_dv = 1'b0;
  endtask

  initial begin
    int img [11][11];
    logic [71:0] ew;
    s_rst = 1'b1; s_dv = 1'b0; s_din = '0;
    b_rst = 1'b1; b_dv = 1'b0; b_din = '0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_s_wv", s_wv, 0);
    check("rst_s_fd", s_fd, 0);
    check("rst_s_win", s_win, 0);
    check("rst_s_crow", s_cr, 0);
    check("rst_s_ccol", s_cc, 0);
    check("rst_b_wv", b_wv, 0);
    check("rst_b_win", b_win, 0);
    s_rst = 1'b0;
    b_rst = 1'b0;
    @(posedge clk); #1;

    // Continuous full frame
    win_cnt = 0; fd_cnt = 0;
    send4(0, 1'b0, 16);
    check("full_win_cnt", win_cnt, 4);
    check("full_fd_cnt", fd_cnt, 1);

    // Same frame with a gap after every pixel
    win_cnt = 0; fd_cnt = 0;
    send4(0, 1'b1, 16);
    check("gap_win_cnt", win_cnt, 4);
    check("gap_fd_cnt", fd_cnt, 1);

    // Back-to-back frames, second offset by 100
    win_cnt = 0; fd_cnt = 0;
    send4(0, 1'b0, 16);
    send4(100, 1'b0, 16);
    check("b2b_win_cnt", win_cnt, 8);
    check("b2b_fd_cnt", fd_cnt, 2);

    // Abort after pixel 10 with a one-cycle reset
    win_cnt = 0; fd_cnt = 0;
    send4(0, 1'b0, 10);
    s_rst = 1'b1;
    @(posedge clk); #1;
    check("abort_wv", s_wv, 0);
    check("abort_fd", s_fd, 0);
    check("abort_win", s_win, 0);
    check("abort_crow", s_cr, 0);
    check("abort_ccol", s_cc, 0);
    s_rst = 1'b0;
    win_cnt = 0; fd_cnt = 0;
    send4(0, 1'b0, 16);
    check("abort_win_cnt", win_cnt, 4);
    check("abort_fd_cnt", fd_cnt, 1);

    // 11x11 random frame against the image model
    for (int r = 0; r < 11; r++) begin
      for (int c = 0; c < 11; c++) begin
        img[r][c] = int'($urandom_range(0, 255));
      end
    end
    win_cnt = 0; fd_cnt = 0;
    for (int r = 0; r < 11; r++) begin
      for (int c = 0; c < 11; c++) begin
        b_din = 8'(img[r][c]);
        b_dv  = 1'b1;
        @(posedge clk); #1;
        check("big_wv", b_wv, (r >= 2) && (c >= 2));
        check("big_fd", b_fd, (r == 10) && (c == 10));
        if (b_wv) win_cnt++;
        if (b_fd) fd_cnt++;
        if ((r >= 2) && (c >= 2)) begin
          ew = '0;
          for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
              ew[(i*3+j)*8 +: 8] = 8'(img[r-2+i][c-2+j]);
            end
          end
          check("big_win", b_win, ew);
          check("big_crow", b_cr, r - 1);
          check("big_ccol", b_cc, c - 1);
        end
      end
    end
    b_dv = 1'b0;
    check("big_win_cnt", win_cnt, 81);
    check("big_fd_cnt", fd_cnt, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
